aurora_link_watchdog: RTL and testbench
=======================================

AURORA_LINK_WATCHDOG -- requirements
Module: aurora_link_watchdog

Interface
REQ-001 SHALL have parameter RESET_PULSE, default 16: init_rst pulse length in init_clk cycles (≥1).
REQ-002 SHALL have parameter STABLE_CYCLES, default 256: consecutive synchronized channel_up cycles before the link is declared up.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535: cycles allowed from end of pulse to link declared up (≤65535).
REQ-004 SHALL have parameter MAX_RETRIES, default 7: failed attempts tolerated before FAIL (1..15).
REQ-005 SHALL have ports: init_clk in 1, clock; RST in 1, reset (synchronous, active-high; clock init_clk).
REQ-006 SHALL have ports: channel_up in 1, Aurora channel status; hard_err in 1, Aurora hard error (both level, asynchronous to init_clk).
REQ-007 SHALL have port clear_fail in 1: leaves FAIL, synchronous to init_clk.
REQ-008 SHALL have port init_rst out 1: drives RST of the Aurora init sequencer.
REQ-009 SHALL have ports: link_ok out 1; link_fail out 1; retry_count out 4; state_dbg out 3.

Function
REQ-010 SHALL pass channel_up and hard_err through 2-flop synchronizers; all logic SHALL use only the synchronized versions (cu_s, he_s).
REQ-011 SHALL implement FSM states PULSE=0, WAIT_UP=1, STABLE=2, UP=3, FAIL=4, driven on state_dbg.
REQ-012 SHALL drive init_rst=1 in PULSE and FAIL, 0 elsewhere; link_ok=1 only in UP; link_fail=1 only in FAIL; all Moore, decoded from the state register.
REQ-013 PULSE: SHALL hold for exactly RESET_PULSE cycles, then enter WAIT_UP with the timeout counter cleared to 0.
REQ-014 The timeout counter (16 bit, saturating) SHALL increment every cycle in WAIT_UP and STABLE and SHALL NOT clear on STABLE->WAIT_UP.
REQ-015 WAIT_UP: on cu_s=1, SHALL enter STABLE with the stable counter cleared.
REQ-016 STABLE: SHALL count consecutive cu_s=1 cycles; cu_s=0 SHALL return to WAIT_UP; when the count reaches STABLE_CYCLES SHALL enter UP and clear retry_count to 0.
REQ-017 In WAIT_UP or STABLE, timeout counter == TIMEOUT_CYCLES SHALL trigger a retry; timeout SHALL take priority over a simultaneous cu_s transition.
REQ-018 he_s=1 in STABLE or UP SHALL trigger a retry next edge; in WAIT_UP it SHALL be ignored.
REQ-019 UP: cu_s=0 or he_s=1 SHALL trigger a retry.
REQ-020 Retry: if retry_count == MAX_RETRIES, SHALL enter FAIL (retry_count unchanged); otherwise retry_count += 1 and enter PULSE.
REQ-021 FAIL: SHALL persist until clear_fail=1, then enter PULSE with retry_count=0.
REQ-022 clear_fail SHALL be ignored outside FAIL.
REQ-023 State transition latency from a synchronized input change SHALL be one init_clk edge; input-pin to output latency SHALL be 3 edges.

Reset
REQ-024 On RST: state=PULSE, init_rst=1, link_ok=0, link_fail=0, retry_count=0, counters=0, synchronizers=0.
REQ-025 RST mid-operation (any state, including FAIL) SHALL abort and restart a full RESET_PULSE pulse starting at the first cycle after RST deasserts.

Structure
REQ-026 State encoding localparams and the counter width constant SHALL reside in the shared package aurora_pkg.
REQ-027 The 2-flop synchronizer SHALL be a sub-module named sync_2ff, instantiated once per asynchronous input.
REQ-028 Single init_clk domain; no combinational path from inputs to outputs.

Verification (RESET_PULSE=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=100, MAX_RETRIES=3)
REQ-029 RST released, channel_up=1 held -> init_rst high for 4 cycles; link_ok=1 at 3+8+1 cycles after WAIT_UP entry (sync + stable + transition); retry_count=0.
REQ-030 channel_up toggles 1 for 5 cycles, then 0, then stays 1 -> no UP until 8 consecutive high cycles; timeout counter not cleared in the meantime.
REQ-031 channel_up held 0 -> retry every 4+100 cycles, retry_count 1,2,3; 4th timeout -> FAIL, init_rst=1, link_fail=1; clear_fail pulse -> PULSE, retry_count=0.
REQ-032 In UP, hard_err pulsed 3 cycles -> init_rst=1 three edges after the hard_err rising edge, link_ok=0, retry_count=1.
REQ-033 channel_up rises in the same cycle the timeout counter hits 100 -> retry (PULSE), not STABLE.
REQ-034 RST asserted in STABLE, then in FAIL -> all outputs return to reset values next edge; full 4-cycle pulse follows.

Source files
------------

// File: rtl/aurora_pkg.sv
// Shared state encoding and counter helpers for the Aurora link watchdog.
package aurora_pkg;

    localparam int CNT_W = 16;

    localparam logic [2:0] ST_PULSE   = 3'd0;
    localparam logic [2:0] ST_WAIT_UP = 3'd1;
    localparam logic [2:0] ST_STABLE  = 3'd2;
    localparam logic [2:0] ST_UP      = 3'd3;
    localparam logic [2:0] ST_FAIL    = 3'd4;

    typedef enum logic [2:0] {
        LS_PULSE   = ST_PULSE,
        LS_WAIT_UP = ST_WAIT_UP,
        LS_STABLE  = ST_STABLE,
        LS_UP      = ST_UP,
        LS_FAIL    = ST_FAIL
    } link_st_e;

    // Saturating increment: the timeout counter must never wrap back to 0.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a level signal entering the init_clk domain.
module sync_2ff (
    input  logic init_clk,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge init_clk) begin
        if (RST) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aurora_link_watchdog.sv
// Supervises Aurora channel bring-up: pulses init_rst, waits for a stable
// channel, retries on timeout/hard error and latches FAIL after too many tries.
module aurora_link_watchdog
    import aurora_pkg::*;
#(
    parameter int RESET_PULSE    = 16,
    parameter int STABLE_CYCLES  = 256,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int MAX_RETRIES    = 7
) (
    input  logic       init_clk,
    input  logic       RST,
    input  logic       channel_up,
    input  logic       hard_err,
    input  logic       clear_fail,
    output logic       init_rst,
    output logic       link_ok,
    output logic       link_fail,
    output logic [3:0] retry_count,
    output logic [2:0] state_dbg
);

    localparam int PW = (RESET_PULSE   > 1) ? $clog2(RESET_PULSE + 1)   : 1;
    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;

    localparam logic [PW-1:0]    PULSE_LAST = PW'(RESET_PULSE - 1);
    localparam logic [SW-1:0]    STAB_LIM   = SW'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] TO_LIM     = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]       RC_MAX     = 4'(MAX_RETRIES);

    logic [1:0] async_in, sync_out;
    logic       cu_s, he_s;

    assign async_in = {hard_err, channel_up};

    for (genvar i = 0; i < 2; i++) begin : g_sync
        sync_2ff u_sync (
            .init_clk (init_clk),
            .RST      (RST),
            .d        (async_in[i]),
            .q        (sync_out[i])
        );
    end

    assign cu_s = sync_out[0];
    assign he_s = sync_out[1];

    link_st_e         st, nxt;
    logic [PW-1:0]    pulse_cnt;
    logic [SW-1:0]    stab_cnt;
    logic [CNT_W-1:0] to_cnt;
    logic             retry, rc_clr, timed_out;

    assign timed_out = (to_cnt == TO_LIM);

    always_comb begin
        nxt       = st;
        retry     = 1'b0;
        rc_clr    = 1'b0;
        init_rst  = 1'b0;
        link_ok   = 1'b0;
        link_fail = 1'b0;
        state_dbg = st;
        case (st)
            LS_PULSE: begin
                init_rst = 1'b1;
                if (pulse_cnt == PULSE_LAST) nxt = LS_WAIT_UP;
            end
            LS_WAIT_UP: begin
                // Timeout wins over a channel that comes up in the same cycle.
                if (timed_out)  retry = 1'b1;
                else if (cu_s)  nxt   = LS_STABLE;
            end
            LS_STABLE: begin
                if (timed_out || he_s) retry = 1'b1;
                else if (stab_cnt == STAB_LIM) begin
                    nxt    = LS_UP;
                    rc_clr = 1'b1;
                end else if (!cu_s) nxt = LS_WAIT_UP;
            end
            LS_UP: begin
                link_ok = 1'b1;
                if (!cu_s || he_s) retry = 1'b1;
            end
            LS_FAIL: begin
                init_rst  = 1'b1;
                link_fail = 1'b1;
                if (clear_fail) begin
                    nxt    = LS_PULSE;
                    rc_clr = 1'b1;
                end
            end
            default: nxt = LS_PULSE;
        endcase
        if (retry) nxt = (retry_count == RC_MAX) ? LS_FAIL : LS_PULSE;
    end

    always_ff @(posedge init_clk) begin
        if (RST) begin
            st          <= LS_PULSE;
            pulse_cnt   <= '0;
            stab_cnt    <= '0;
            to_cnt      <= '0;
            retry_count <= '0;
        end else begin
            st        <= nxt;
            pulse_cnt <= (st == LS_PULSE  && nxt == LS_PULSE)  ? pulse_cnt + 1'b1 : '0;
            stab_cnt  <= (st == LS_STABLE && nxt == LS_STABLE) ? stab_cnt + 1'b1  : '0;
            // Keeps running across STABLE->WAIT_UP bounces; only PULSE/UP/FAIL clear it.
            to_cnt    <= (st == LS_WAIT_UP || st == LS_STABLE) ? sat_inc(to_cnt) : '0;
            if (rc_clr)
                retry_count <= '0;
            else if (retry && nxt == LS_PULSE)
                retry_count <= retry_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_aurora_link_watchdog.sv
// Randomized + directed bench for aurora_link_watchdog against a timestamp-based model.
module tb_aurora_link_watchdog;

    localparam int RP = 4;
    localparam int SC = 8;
    localparam int TO = 100;
    localparam int MR = 3;

    logic       init_clk = 1'b0;
    logic       RST = 1'b1;
    logic       channel_up = 1'b0;
    logic       hard_err = 1'b0;
    logic       clear_fail = 1'b0;
    logic       init_rst, link_ok, link_fail;
    logic [3:0] retry_count;
    logic [2:0] state_dbg;

    int checks = 0;
    int fails  = 0;

    aurora_link_watchdog #(
        .RESET_PULSE    (RP),
        .STABLE_CYCLES  (SC),
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRIES    (MR)
    ) dut (
        .init_clk    (init_clk),
        .RST         (RST),
        .channel_up  (channel_up),
        .hard_err    (hard_err),
        .clear_fail  (clear_fail),
        .init_rst    (init_rst),
        .link_ok     (link_ok),
        .link_fail   (link_fail),
        .retry_count (retry_count),
        .state_dbg   (state_dbg)
    );

    always #5 init_clk = ~init_clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase code (0 pulse,1 wait,2 stable,3 up,4 fail) plus edge timestamps.
    int         m_ph = 0, m_start = 0, m_wstart = 0, m_rc = 0, cyc = 0;
    logic [1:0] cu_h = 2'b00, he_h = 2'b00;

    function automatic int elapsed(input int c);
        int e;
        e = c - m_wstart - 1;
        return (e > 65535) ? 65535 : e;
    endfunction

    task automatic model_step();
        int  nph;
        bit  cu, he, rty;
        cu = cu_h[1];
        he = he_h[1];
        if (RST) begin
            m_ph = 0; m_start = cyc; m_rc = 0; cu_h = 2'b00; he_h = 2'b00;
        end else begin
            nph = m_ph; rty = 0;
            case (m_ph)
                0: if (cyc - m_start >= RP) begin nph = 1; m_wstart = cyc; end
                1: if (elapsed(cyc) == TO) rty = 1; else if (cu) nph = 2;
                2: if (elapsed(cyc) == TO || he) rty = 1;
                   else if (cyc - m_start - 1 == SC) begin nph = 3; m_rc = 0; end
                   else if (!cu) nph = 1;
                3: if (!cu || he) rty = 1;
                default: if (clear_fail) begin nph = 0; m_rc = 0; end
            endcase
            if (rty) begin
                if (m_rc == MR) nph = 4;
                else begin m_rc++; nph = 0; end
            end
            if (nph != m_ph) m_start = cyc;
            m_ph = nph;
            cu_h = {cu_h[0], channel_up};
            he_h = {he_h[0], hard_err};
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge init_clk);
        model_step();
    end

    initial forever begin
        @(negedge init_clk);
        chk("m_init_rst",  init_rst,    (m_ph == 0 || m_ph == 4));
        chk("m_link_ok",   link_ok,     (m_ph == 3));
        chk("m_link_fail", link_fail,   (m_ph == 4));
        chk("m_retry",     retry_count, m_rc);
        chk("m_state",     state_dbg,   m_ph);
    end

    function automatic bit cond(input int sel);
        case (sel)
            0: return link_ok;
            1: return link_fail;
            2: return init_rst;
            3: return state_dbg == 3'd2;
            default: return state_dbg == 3'd1;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int bound, output int n);
        n = 0;
        while (n < bound) begin
            @(negedge init_clk);
            n++;
            if (cond(sel)) return;
        end
        n = -1;
    endtask

    task automatic pulse_len(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (init_rst && state_dbg == 3'd0) n++;
            else break;
            @(negedge init_clk);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_state"},  state_dbg, 0);
        chk({nm, "_irst"},   init_rst, 1);
        chk({nm, "_ok"},     link_ok, 0);
        chk({nm, "_lfail"},  link_fail, 0);
        chk({nm, "_rc"},     retry_count, 0);
    endtask

    initial begin
        int n;
        // Power-on reset and first bring-up with channel rising at WAIT_UP entry.
        repeat (3) @(negedge init_clk);
        chk_reset("por");
        RST = 1'b0;
        pulse_len(n);
        chk("pulse_len0", n, 4);
        chk("wait_entry", state_dbg, 1);
        channel_up = 1'b1;
        wait_for(0, 50, n);
        chk("up_latency", n, 12);
        chk("up_rc", retry_count, 0);

        // Hard error while up: three edges to init_rst.
        repeat (5) @(negedge init_clk);
        hard_err = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge init_clk);
            n++;
            if (n == 3) hard_err = 1'b0;
            if (init_rst) break;
        end
        hard_err = 1'b0;
        chk("he_latency", n, 3);
        chk("he_ok", link_ok, 0);
        chk("he_rc", retry_count, 1);
        wait_for(0, 100, n);
        chk("he_reup", n > 0, 1);
        chk("he_reup_rc", retry_count, 0);

        // Channel bounce: 5 high, 1 low, then held high.
        channel_up = 1'b0; RST = 1'b1;
        @(negedge init_clk);
        RST = 1'b0;
        pulse_len(n);
        chk("pulse_len1", n, 4);
        channel_up = 1'b1;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge init_clk);
            n++;
            if (n == 5) channel_up = 1'b0;
            if (n == 6) channel_up = 1'b1;
            if (link_ok) break;
        end
        chk("bounce_up", n, 18);

        // Fast toggling never stabilizes: timeout counts from WAIT_UP entry.
        channel_up = 1'b0; RST = 1'b1;
        @(negedge init_clk);
        RST = 1'b0;
        pulse_len(n);
        channel_up = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge init_clk);
            n++;
            if (init_rst) break;
            channel_up = ((n / 4) % 2 == 0);
        end
        chk("toggle_timeout", n, 101);
        chk("toggle_rc", retry_count, 1);

        // Channel dead: remaining timeouts lead to FAIL.
        channel_up = 1'b0;
        wait_for(1, 1000, n);
        chk("fail_time", n, 315);
        chk("fail_rc", retry_count, 3);
        chk("fail_irst", init_rst, 1);
        chk("fail_state", state_dbg, 4);
        repeat (10) @(negedge init_clk);
        chk("fail_hold", link_fail, 1);
        clear_fail = 1'b1;
        @(negedge init_clk);
        clear_fail = 1'b0;
        chk("clr_state", state_dbg, 0);
        chk("clr_rc", retry_count, 0);
        chk("clr_lfail", link_fail, 0);

        // Channel rises exactly when the timeout counter hits the limit.
        wait_for(4, 20, n);
        chk("to_wait_entry", n, 4);
        repeat (98) @(negedge init_clk);
        channel_up = 1'b1;
        @(negedge init_clk);
        chk("to_edge99", state_dbg, 1);
        @(negedge init_clk);
        chk("to_edge100", state_dbg, 1);
        @(negedge init_clk);
        chk("to_priority", state_dbg, 0);
        chk("to_rc", retry_count, 1);

        // Reset during STABLE, then during FAIL.
        wait_for(3, 50, n);
        chk("reach_stable", n > 0, 1);
        RST = 1'b1;
        @(negedge init_clk);
        chk_reset("rst_stable");
        RST = 1'b0;
        pulse_len(n);
        chk("pulse_len2", n, 4);
        channel_up = 1'b0;
        wait_for(1, 2000, n);
        chk("reach_fail2", n > 0, 1);
        RST = 1'b1;
        @(negedge init_clk);
        chk_reset("rst_fail");
        RST = 1'b0;
        pulse_len(n);
        chk("pulse_len3", n, 4);

        // Random soak against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge init_clk);
            if ($urandom_range(0, 39) == 0) channel_up = ~channel_up;
            hard_err   = ($urandom_range(0, 299) == 0);
            clear_fail = ($urandom_range(0, 29) == 0);
            RST        = ($urandom_range(0, 1999) == 0);
        end
        @(negedge init_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
